// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared definitions for the IF-ID-EX-WB issue controller of the 8-bit, 8-register core.
package pipe_issue_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_LAST = 2'd2
  } state_e;

  localparam int REG_W  = 3;
  localparam int DATA_W = 8;
endpackage

// File: rtl/pipe_issue_ctrl_stall_counter.sv
// Saturating event counter; advances once per enabled cycle and sticks at all-ones.
module pipe_issue_ctrl_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue sequencing for the ID/EX and EX/WB registers: multi-cycle EX stall FSM,
// flush/hold overrides, WB->EX operand forwarding and a stall-cycle counter.
module pipe_issue_ctrl
  import pipe_issue_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Hold,
  input  logic             Flush,
  input  logic             Ex_Multi,
  input  logic [REG_W-1:0] Ex_Rs1,
  input  logic [REG_W-1:0] Ex_Rs2,
  input  logic             Wb_RegWrite,
  input  logic [REG_W-1:0] Wb_Rd,
  output logic             Stall,
  output logic             ID_EX_En,
  output logic             ID_EX_Bubble,
  output logic             EX_WB_En,
  output logic             EX_WB_Bubble,
  output logic             Mc_Start,
  output logic             Mc_Result_Sel,
  output logic             Fwd_Sel1,
  output logic             Fwd_Sel2,
  output logic [CNT_W-1:0] Stall_Cnt
);
  // Start cycle and MC_LAST each take one EX cycle; MC_BUSY covers the rest.
  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wb_live_q, wb_live_d;
  logic       fwd_ok;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      wb_live_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_live_q <= wb_live_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (!Hold) begin
      case (state_q)
        RUN: if (Ex_Multi) begin
          if (MC_LAT > 2) begin
            state_d = MC_BUSY;
            cnt_d   = MC_INIT;
          end else begin
            state_d = MC_LAST;
          end
        end
        MC_BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = MC_LAST;
        end
        MC_LAST: state_d = RUN;
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    Stall         = 1'b0;
    ID_EX_En      = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_WB_En      = 1'b1;
    EX_WB_Bubble  = 1'b0;
    Mc_Start      = 1'b0;
    Mc_Result_Sel = 1'b0;
    fwd_ok        = 1'b0;
    case (state_q)
      RUN: begin
        fwd_ok = 1'b1;
        if (Ex_Multi) begin
          Mc_Start     = 1'b1;
          Stall        = 1'b1;
          ID_EX_En     = 1'b0;
          EX_WB_Bubble = 1'b1;
        end
      end
      MC_BUSY: begin
        Stall        = 1'b1;
        ID_EX_En     = 1'b0;
        EX_WB_Bubble = 1'b1;
      end
      MC_LAST: begin
        Mc_Result_Sel = 1'b1;
        fwd_ok        = wb_live_q;
      end
      default: ;
    endcase
    // A flushed multi-cycle op, at any point of its EX residency, never writes back.
    if (Flush) begin
      Stall         = 1'b0;
      ID_EX_En      = 1'b1;
      ID_EX_Bubble  = 1'b1;
      EX_WB_En      = 1'b1;
      EX_WB_Bubble  = EX_WB_Bubble || (state_q == MC_LAST);
      Mc_Start      = 1'b0;
      Mc_Result_Sel = 1'b0;
    end else if (Hold) begin
      Stall         = 1'b1;
      ID_EX_En      = 1'b0;
      EX_WB_En      = 1'b0;
      Mc_Start      = 1'b0;
      Mc_Result_Sel = 1'b0;
    end
  end

  // Tracks whether EX/WB currently holds a real instruction or a bubble.
  always_comb begin
    wb_live_d = wb_live_q;
    if (EX_WB_En) wb_live_d = !EX_WB_Bubble;
  end

  assign Fwd_Sel1 = Wb_RegWrite && (Wb_Rd == Ex_Rs1) && fwd_ok;
  assign Fwd_Sel2 = Wb_RegWrite && (Wb_Rd == Ex_Rs2) && fwd_ok;

  pipe_issue_ctrl_stall_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (Stall),
    .cnt   (Stall_Cnt)
  );
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Vector/scoreboard bench: one instance with MC_LAT=4, one with MC_LAT=2 and a 3-bit counter.
module tb_pipe_issue_ctrl;
  typedef struct {
    string       nm;
    bit          d2;
    logic        hold, flush, multi;
    logic [2:0]  rs1, rs2;
    logic        wrw;
    logic [2:0]  wrd;
    logic [8:0]  o;
    logic [15:0] c;
  } vec_t;

  logic Clk, Reset, Hold, Flush, Ex_Multi, Wb_RegWrite;
  logic [2:0] Ex_Rs1, Ex_Rs2, Wb_Rd;
  logic st4, ide4, idb4, ewe4, ewb4, ms4, mr4, f14, f24;
  logic st2, ide2, idb2, ewe2, ewb2, ms2, mr2, f12, f22;
  logic [15:0] cnt4;
  logic [2:0]  cnt2;
  logic [8:0]  o4, o2;

  int n_chk = 0;
  int n_fail = 0;
  vec_t exp_q[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  pipe_issue_ctrl #(.MC_LAT(4), .CNT_W(16)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Hold(Hold), .Flush(Flush), .Ex_Multi(Ex_Multi),
    .Ex_Rs1(Ex_Rs1), .Ex_Rs2(Ex_Rs2), .Wb_RegWrite(Wb_RegWrite), .Wb_Rd(Wb_Rd),
    .Stall(st4), .ID_EX_En(ide4), .ID_EX_Bubble(idb4), .EX_WB_En(ewe4),
    .EX_WB_Bubble(ewb4), .Mc_Start(ms4), .Mc_Result_Sel(mr4),
    .Fwd_Sel1(f14), .Fwd_Sel2(f24), .Stall_Cnt(cnt4));

  pipe_issue_ctrl #(.MC_LAT(2), .CNT_W(3)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Hold(Hold), .Flush(Flush), .Ex_Multi(Ex_Multi),
    .Ex_Rs1(Ex_Rs1), .Ex_Rs2(Ex_Rs2), .Wb_RegWrite(Wb_RegWrite), .Wb_Rd(Wb_Rd),
    .Stall(st2), .ID_EX_En(ide2), .ID_EX_Bubble(idb2), .EX_WB_En(ewe2),
    .EX_WB_Bubble(ewb2), .Mc_Start(ms2), .Mc_Result_Sel(mr2),
    .Fwd_Sel1(f12), .Fwd_Sel2(f22), .Stall_Cnt(cnt2));

  // {Stall, ID_EX_En, ID_EX_Bubble, EX_WB_En, EX_WB_Bubble, Mc_Start, Mc_Result_Sel, Fwd1, Fwd2}
  assign o4 = {st4, ide4, idb4, ewe4, ewb4, ms4, mr4, f14, f24};
  assign o2 = {st2, ide2, idb2, ewe2, ewb2, ms2, mr2, f12, f22};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input bit d2, input logic h, input logic f,
                              input logic m, input logic [2:0] r1, input logic [2:0] r2,
                              input logic w, input logic [2:0] rd, input logic [8:0] o,
                              input logic [15:0] c);
    vec_t v;
    v.nm = nm; v.d2 = d2; v.hold = h; v.flush = f; v.multi = m;
    v.rs1 = r1; v.rs2 = r2; v.wrw = w; v.wrd = rd; v.o = o; v.c = c;
    return v;
  endfunction

  // Drive at posedge+1, compare at the following negedge.
  task automatic apply(input vec_t v);
    Hold = v.hold; Flush = v.flush; Ex_Multi = v.multi;
    Ex_Rs1 = v.rs1; Ex_Rs2 = v.rs2; Wb_RegWrite = v.wrw; Wb_Rd = v.wrd;
    exp_q.push_back(v);
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin : scb
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.d2) begin
        chk({e.nm, ".out"}, {7'd0, o2}, {7'd0, e.o});
        chk({e.nm, ".cnt"}, {13'd0, cnt2}, e.c);
      end else begin
        chk({e.nm, ".out"}, {7'd0, o4}, {7'd0, e.o});
        chk({e.nm, ".cnt"}, cnt4, e.c);
      end
    end
  end

  initial begin
    tbl_a.push_back(mk("fwd_rs1",     0, 0, 0, 0, 3'd3, 3'd5, 1, 3'd3, 9'b010100010, 16'd0));
    tbl_a.push_back(mk("fwd_rs2",     0, 0, 0, 0, 3'd5, 3'd3, 1, 3'd3, 9'b010100001, 16'd0));
    tbl_a.push_back(mk("fwd_r0",      0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd0, 9'b010100011, 16'd0));
    tbl_a.push_back(mk("fwd_nowr",    0, 0, 0, 0, 3'd3, 3'd3, 0, 3'd3, 9'b010100000, 16'd0));
    tbl_a.push_back(mk("mc_start",    0, 0, 0, 1, 3'd2, 3'd6, 1, 3'd2, 9'b100111010, 16'd0));
    tbl_a.push_back(mk("mc_busy1",    0, 0, 0, 1, 3'd2, 3'd6, 1, 3'd2, 9'b100110000, 16'd1));
    tbl_a.push_back(mk("mc_busy2",    0, 0, 0, 1, 3'd2, 3'd6, 1, 3'd2, 9'b100110000, 16'd2));
    tbl_a.push_back(mk("mc_last",     0, 0, 0, 1, 3'd2, 3'd6, 1, 3'd2, 9'b010100100, 16'd3));
    tbl_a.push_back(mk("after_mc",    0, 0, 0, 0, 3'd2, 3'd6, 1, 3'd2, 9'b010100010, 16'd3));
    tbl_a.push_back(mk("h_start",     0, 0, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b100111000, 16'd3));
    for (int i = 0; i < 5; i++)
      tbl_a.push_back(mk($sformatf("hold_busy%0d", i), 0, 1, 0, 1, 3'd1, 3'd1, 0, 3'd1,
                         9'b100010000, 16'(4 + i)));
    tbl_a.push_back(mk("unhold_b2",   0, 0, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b100110000, 16'd9));
    tbl_a.push_back(mk("unhold_b1",   0, 0, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b100110000, 16'd10));
    tbl_a.push_back(mk("unhold_last", 0, 0, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b010100100, 16'd11));
    tbl_a.push_back(mk("hold_run",    0, 1, 0, 0, 3'd1, 3'd1, 0, 3'd1, 9'b100000000, 16'd11));
    tbl_a.push_back(mk("hold_defer",  0, 1, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b100010000, 16'd12));
    tbl_a.push_back(mk("defer_start", 0, 0, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b100111000, 16'd13));
    tbl_a.push_back(mk("fl_busy1",    0, 0, 0, 1, 3'd1, 3'd1, 0, 3'd1, 9'b100110000, 16'd14));
    tbl_a.push_back(mk("fl_busy2",    0, 0, 1, 1, 3'd1, 3'd1, 0, 3'd1, 9'b011110000, 16'd15));
    tbl_a.push_back(mk("post_flush",  0, 0, 0, 0, 3'd1, 3'd4, 1, 3'd1, 9'b010100010, 16'd15));
    tbl_a.push_back(mk("fl_over_h",   0, 1, 1, 0, 3'd1, 3'd4, 1, 3'd1, 9'b011100010, 16'd15));
    tbl_a.push_back(mk("fl_start",    0, 0, 1, 1, 3'd1, 3'd4, 0, 3'd1, 9'b011110000, 16'd15));
    tbl_a.push_back(mk("fl_after",    0, 0, 0, 0, 3'd1, 3'd4, 0, 3'd1, 9'b010100000, 16'd15));
    tbl_a.push_back(mk("rst_start",   0, 0, 0, 1, 3'd1, 3'd4, 0, 3'd1, 9'b100111000, 16'd15));
    tbl_a.push_back(mk("rst_busy",    0, 0, 0, 1, 3'd1, 3'd4, 0, 3'd1, 9'b100110000, 16'd16));

    tbl_b.push_back(mk("b2b_s1",      1, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 9'b100111000, 16'd0));
    tbl_b.push_back(mk("b2b_l1",      1, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 9'b010100100, 16'd1));
    tbl_b.push_back(mk("b2b_s2",      1, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 9'b100111000, 16'd1));
    tbl_b.push_back(mk("b2b_l2",      1, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 9'b010100100, 16'd2));
    tbl_b.push_back(mk("b2b_run",     1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 9'b010100000, 16'd2));
    for (int i = 0; i < 8; i++)
      tbl_b.push_back(mk($sformatf("sat_hold%0d", i), 1, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0,
                         9'b100000000, (i < 5) ? 16'(2 + i) : 16'd7));
    tbl_b.push_back(mk("sat_end",     1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 9'b010100000, 16'd7));

    Reset = 1'b0; Hold = 1'b0; Flush = 1'b0; Ex_Multi = 1'b0;
    Ex_Rs1 = '0; Ex_Rs2 = '0; Wb_RegWrite = 1'b0; Wb_Rd = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out4", {7'd0, o4}, 16'h00A0);
    chk("rst_cnt4", cnt4, 16'd0);
    chk("rst_cnt2", {13'd0, cnt2}, 16'd0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    foreach (tbl_a[i]) apply(tbl_a[i]);

    // Asynchronous reset in the middle of MC_BUSY: back to RUN, counter cleared.
    Ex_Multi = 1'b1;
    #2 Reset = 1'b0;
    #1;
    chk("arst_start", {15'd0, ms4}, 16'd1);
    chk("arst_stall", {15'd0, st4}, 16'd1);
    chk("arst_cnt4", cnt4, 16'd0);
    Ex_Multi = 1'b0;
    #1;
    chk("arst_run", {7'd0, o4}, 16'h00A0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    foreach (tbl_b[i]) apply(tbl_b[i]);
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
